// File: rtl/tlb_reader.sv
// ---------------------------------------------------------------------------
// tlb_reader -- TLBR / TLBP sequencer for the CP0 TLB array.
//
// Runs one of two operations against a synchronous-read TLB array:
//   * read  (TLBR): fetches entry cp0_index[5:0] and returns its three words.
//   * probe (TLBP): scans entries 0..63 and reports the lowest index whose
//                   VPN2 matches and whose ASID matches or which is global.
// When both requests arrive together the probe runs and the read is dropped.
// Requests are only accepted in IDLE; anything raised while busy is lost.
//
// Configuration macro: TLB_PROBE_EARLY_EXIT_EN
//   defined   -> the probe stops at the first match (done at cycle k+i+2)
//   undefined -> the probe always scans all 64 entries (done at cycle k+65)
//
// Ports:
//   clk           clock, all state on the rising edge
//   res           asynchronous reset, active low
//   req_read      TLBR request (sampled in IDLE)
//   req_probe     TLBP request (sampled in IDLE, wins over req_read)
//   cp0_index     Index register, [5:0] = entry for TLBR
//   cp0_entryHi   EntryHi, VPN2 = [31:13], ASID = [7:0]
//   tlb_rd_en     array read strobe
//   tlb_rd_idx    array read address
//   tlb_rd_data   {entryHi, entryLo0, entryLo1}, valid the cycle after rd_en
//   busy          high in every non-IDLE state
//   done          one-cycle completion pulse
//   out_index     probe result, bit31 = P (no match), [5:0] = matching entry
//   out_entryHi / out_entryLo0 / out_entryLo1   read result
//   wr_index      pulses with done after a probe
//   wr_entry      pulses with done after a read
// ---------------------------------------------------------------------------
module tlb_reader (
   input  logic        clk,
   input  logic        res,
   input  logic        req_read,
   input  logic        req_probe,
   input  logic [31:0] cp0_index,
   input  logic [31:0] cp0_entryHi,
   output logic        tlb_rd_en,
   output logic [5:0]  tlb_rd_idx,
   input  logic [95:0] tlb_rd_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] out_index,
   output logic [31:0] out_entryHi,
   output logic [31:0] out_entryLo0,
   output logic [31:0] out_entryLo1,
   output logic        wr_index,
   output logic        wr_entry
);

`ifdef TLB_PROBE_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_RD_WAIT = 3'd2,
      S_PROBE   = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   // Entry match: VPN2 equal, and either global (G set in both halves) or ASID equal.
   function automatic logic tlb_match(input logic [95:0] entry,
                                      input logic [18:0] vpn2,
                                      input logic [7:0]  asid);
      logic [31:0] hi;
      logic [31:0] lo0;
      logic [31:0] lo1;
      {hi, lo0, lo1} = entry;
      return (hi[31:13] == vpn2) && ((lo0[0] && lo1[0]) || (hi[7:0] == asid));
   endfunction

   state_t      state_q, state_d;
   logic        rd_en_q, rd_en_d;
   logic [5:0]  rd_idx_q, rd_idx_d;
   logic [6:0]  issue_q, issue_d;          // next probe index to issue; bit6 = all issued
   logic        pend_q, pend_d;            // tlb_rd_data holds a probe entry this cycle
   logic [5:0]  pend_idx_q, pend_idx_d;    // index of that entry
   logic        found_q, found_d;
   logic [5:0]  found_idx_q, found_idx_d;
   logic [18:0] vpn2_q, vpn2_d;            // EntryHi snapshot taken at the request edge
   logic [7:0]  asid_q, asid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        wr_index_q, wr_index_d;
   logic        wr_entry_q, wr_entry_d;
   logic [31:0] out_index_q, out_index_d;
   logic [31:0] out_hi_q, out_hi_d;
   logic [31:0] out_lo0_q, out_lo0_d;
   logic [31:0] out_lo1_q, out_lo1_d;
   logic        hit_s;
   logic        finish_s;
   logic        unused_s;

   // Upper Index bits and EntryHi[12:8] play no part in either operation.
   assign unused_s = ^{cp0_index[31:6], cp0_entryHi[12:8]};

   // Next-state and next-output computation for the whole sequencer.
   always_comb begin
      state_d     = state_q;
      rd_en_d     = 1'b0;
      rd_idx_d    = rd_idx_q;
      issue_d     = issue_q;
      pend_d      = 1'b0;
      pend_idx_d  = pend_idx_q;
      found_d     = found_q;
      found_idx_d = found_idx_q;
      vpn2_d      = vpn2_q;
      asid_d      = asid_q;
      done_d      = 1'b0;
      wr_index_d  = 1'b0;
      wr_entry_d  = 1'b0;
      out_index_d = out_index_q;
      out_hi_d    = out_hi_q;
      out_lo0_d   = out_lo0_q;
      out_lo1_d   = out_lo1_q;
      hit_s       = 1'b0;
      finish_s    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_probe) begin
               state_d     = S_PROBE;
               rd_en_d     = 1'b1;
               rd_idx_d    = 6'd0;
               issue_d     = 7'd1;
               found_d     = 1'b0;
               found_idx_d = 6'd0;
               vpn2_d      = cp0_entryHi[31:13];
               asid_d      = cp0_entryHi[7:0];
            end else if (req_read) begin
               state_d  = S_RD;
               rd_en_d  = 1'b1;
               rd_idx_d = cp0_index[5:0];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            {out_hi_d, out_lo0_d, out_lo1_d} = tlb_rd_data;
            done_d     = 1'b1;
            wr_entry_d = 1'b1;
            state_d    = S_FIN;
         end
         S_PROBE: begin
            // The strobe issued last cycle becomes the entry compared this cycle.
            pend_d     = rd_en_q;
            pend_idx_d = rd_idx_q;
            hit_s      = pend_q && tlb_match(tlb_rd_data, vpn2_q, asid_q);
            if (hit_s && !found_q) begin
               found_d     = 1'b1;
               found_idx_d = pend_idx_q;
            end else begin
               found_d = found_q;
            end
            finish_s = (pend_q && (pend_idx_q == 6'd63)) || (EARLY_EXIT && hit_s);
            if (finish_s) begin
               state_d    = S_FIN;
               done_d     = 1'b1;
               wr_index_d = 1'b1;
               if (found_q) begin
                  out_index_d = {26'd0, found_idx_q};
               end else if (hit_s) begin
                  out_index_d = {26'd0, pend_idx_q};
               end else begin
                  out_index_d = 32'h8000_0000;
               end
            end else if (!issue_q[6]) begin
               rd_en_d  = 1'b1;
               rd_idx_d = issue_q[5:0];
               issue_d  = issue_q + 7'd1;
            end else begin
               rd_en_d = 1'b0;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset aborts any operation without a pulse.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q     <= S_IDLE;
         rd_en_q     <= 1'b0;
         rd_idx_q    <= 6'd0;
         issue_q     <= 7'd0;
         pend_q      <= 1'b0;
         pend_idx_q  <= 6'd0;
         found_q     <= 1'b0;
         found_idx_q <= 6'd0;
         vpn2_q      <= 19'd0;
         asid_q      <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_index_q  <= 1'b0;
         wr_entry_q  <= 1'b0;
         out_index_q <= 32'd0;
         out_hi_q    <= 32'd0;
         out_lo0_q   <= 32'd0;
         out_lo1_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         rd_idx_q    <= rd_idx_d;
         issue_q     <= issue_d;
         pend_q      <= pend_d;
         pend_idx_q  <= pend_idx_d;
         found_q     <= found_d;
         found_idx_q <= found_idx_d;
         vpn2_q      <= vpn2_d;
         asid_q      <= asid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wr_index_q  <= wr_index_d;
         wr_entry_q  <= wr_entry_d;
         out_index_q <= out_index_d;
         out_hi_q    <= out_hi_d;
         out_lo0_q   <= out_lo0_d;
         out_lo1_q   <= out_lo1_d;
      end
   end

   assign tlb_rd_en    = rd_en_q;
   assign tlb_rd_idx   = rd_idx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign wr_index     = wr_index_q;
   assign wr_entry     = wr_entry_q;
   assign out_index    = out_index_q;
   assign out_entryHi  = out_hi_q;
   assign out_entryLo0 = out_lo0_q;
   assign out_entryLo1 = out_lo1_q;

endmodule

// File: tb/tb_tlb_reader.sv
// ---------------------------------------------------------------------------
// tb_tlb_reader -- self-checking bench for tlb_reader.
// A directed vector table, a mid-probe reset sequence and randomized
// read/probe operations are checked against a behavioural TLB model.
// ---------------------------------------------------------------------------
module tb_tlb_reader;

`ifdef TLB_PROBE_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic        clk;
   logic        res;
   logic        req_read;
   logic        req_probe;
   logic [31:0] cp0_index;
   logic [31:0] cp0_entryHi;
   logic        tlb_rd_en;
   logic [5:0]  tlb_rd_idx;
   logic [95:0] tlb_rd_data;
   logic        busy;
   logic        done;
   logic [31:0] out_index;
   logic [31:0] out_entryHi;
   logic [31:0] out_entryLo0;
   logic [31:0] out_entryLo1;
   logic        wr_index;
   logic        wr_entry;

   logic [95:0] mem [64];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] e_idx, e_hi, e_lo0, e_lo1;

   typedef struct {
      bit          rd;
      bit          pr;
      logic [31:0] index;
      logic [31:0] ehi;
      int          inject;
      logic [31:0] key;
      int          lat;
   } vec_t;
   vec_t vecs [11];

   tlb_reader dut (
      .clk          (clk),
      .res          (res),
      .req_read     (req_read),
      .req_probe    (req_probe),
      .cp0_index    (cp0_index),
      .cp0_entryHi  (cp0_entryHi),
      .tlb_rd_en    (tlb_rd_en),
      .tlb_rd_idx   (tlb_rd_idx),
      .tlb_rd_data  (tlb_rd_data),
      .busy         (busy),
      .done         (done),
      .out_index    (out_index),
      .out_entryHi  (out_entryHi),
      .out_entryLo0 (out_entryLo0),
      .out_entryLo1 (out_entryLo1),
      .wr_index     (wr_index),
      .wr_entry     (wr_entry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read TLB array model
   always @(posedge clk) begin
      if (tlb_rd_en) tlb_rd_data <= mem[tlb_rd_idx];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit hit, required the test to complete");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Lowest matching entry per the TLBP rules, -1 when nothing matches.
   function automatic int model_probe(input logic [31:0] ehi);
      logic [31:0] hi, lo0, lo1;
      for (int i = 0; i < 64; i++) begin
         {hi, lo0, lo1} = mem[i];
         if (hi[31:13] == ehi[31:13] && ((lo0[0] && lo1[0]) || hi[7:0] == ehi[7:0]))
            return i;
      end
      return -1;
   endfunction

   task automatic fill_base();
      logic [5:0] b;
      for (int i = 0; i < 64; i++) begin
         b = 6'(i);
         mem[i] = {13'h1AB, b, 5'd0, 8'h33,
                   32'h1000_0000 | {20'd0, b, 6'd0},
                   32'h2000_0000 | {20'd0, b, 6'd0}};
      end
      mem[3]  = {32'h0088_8022, 32'h3000_0001, 32'h4000_0001};
      mem[5]  = {32'h0040_2000, 32'h5555_0000, 32'h6666_0000};
      mem[9]  = {32'h0040_2011, 32'h7777_0000, 32'h8888_0000};
      mem[20] = {32'h0040_2011, 32'h9999_0000, 32'hAAAA_0000};
   endtask

   task automatic fill_random();
      logic [31:0] lo0, lo1;
      int          g, pair;
      for (int i = 0; i < 64; i++) begin
         lo0  = $urandom;
         lo1  = $urandom;
         g    = int'($urandom_range(0, 7));
         pair = int'($urandom_range(0, 2));
         lo0[0] = (g == 0) || (pair == 2);
         lo1[0] = (g == 0) || (pair == 1);
         mem[i] = {19'($urandom_range(0, 40)), 5'($urandom), 8'($urandom_range(0, 3)), lo0, lo1};
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, {22'd0, busy, done, wr_index, wr_entry, tlb_rd_en, tlb_rd_idx}, 32'd0);
      chk({tag, "_out_index"}, out_index, 32'd0);
      chk({tag, "_out_hi"}, out_entryHi, 32'd0);
      chk({tag, "_out_lo0"}, out_entryLo0, 32'd0);
      chk({tag, "_out_lo1"}, out_entryLo1, 32'd0);
   endtask

   // One operation: drive request, follow it to done, check timing and results.
   task automatic run_op(input bit rd, input bit pr, input logic [31:0] idx,
                         input logic [31:0] ehi, input int inject,
                         input bit key_chk, input logic [31:0] key, input int lat_tab);
      int hit, lat, exp_issues, issues, bad_idx, not_busy, done_c, idle_bad;
      if (pr) begin
         hit = model_probe(ehi);
         if (hit < 0) begin
            lat = 65; exp_issues = 64; e_idx = 32'h8000_0000;
         end else begin
            e_idx      = 32'(hit);
            lat        = EE ? hit + 2 : 65;
            exp_issues = EE ? ((hit + 2 > 64) ? 64 : hit + 2) : 64;
         end
      end else begin
         lat = 2; exp_issues = 1;
         {e_hi, e_lo0, e_lo1} = mem[idx[5:0]];
      end
      if (lat_tab >= 0) lat = lat_tab;

      @(negedge clk);
      cp0_index = idx; cp0_entryHi = ehi; req_read = rd; req_probe = pr;
      @(posedge clk);
      issues = 0; bad_idx = 0; not_busy = 0; done_c = -1;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (tlb_rd_en) begin
            issues++;
            if (tlb_rd_idx != (pr ? c[5:0] : idx[5:0])) bad_idx++;
         end
         if (!busy) not_busy++;
         if (done) begin
            done_c = c;
            break;
         end
         @(negedge clk);
         if (c == 0) begin
            req_read = 1'b0; req_probe = 1'b0;
            cp0_index = $urandom; cp0_entryHi = $urandom;
         end
         if (c == inject) req_read = 1'b1;
         else if (c == inject + 1) req_read = 1'b0;
         @(posedge clk);
      end
      chk("latency", 32'(done_c), 32'(lat));
      chk("rd_en_issues", 32'(issues), 32'(exp_issues));
      chk("rd_idx_seq", 32'(bad_idx), 32'd0);
      chk("busy_high", 32'(not_busy), 32'd0);
      chk("wr_index", 32'(wr_index), 32'(pr));
      chk("wr_entry", 32'(wr_entry), 32'(!pr));
      chk("out_index", out_index, e_idx);
      chk("out_entryHi", out_entryHi, e_hi);
      chk("out_entryLo0", out_entryLo0, e_lo0);
      chk("out_entryLo1", out_entryLo1, e_lo1);
      if (key_chk) chk("table_key", pr ? out_index : out_entryHi, key);
      idle_bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (busy || done || wr_index || wr_entry) idle_bad++;
      end
      chk("idle_after", 32'(idle_bad), 32'd0);
   endtask

   task automatic abort_test();
      int pulses;
      pulses = 0;
      @(negedge clk);
      cp0_entryHi = 32'h1234_5678; req_probe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_probe = 1'b0;
      repeat (30) @(posedge clk);
      #3 res = 1'b0;
      #1 chk_all_zero("abort");
      e_idx = 32'd0; e_hi = 32'd0; e_lo0 = 32'd0; e_lo1 = 32'd0;
      @(negedge clk);
      res = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         if (done || wr_index || wr_entry || busy) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
   endtask

   initial begin
      res = 1'b0; req_read = 1'b0; req_probe = 1'b0;
      cp0_index = 32'd0; cp0_entryHi = 32'd0;
      e_idx = 32'd0; e_hi = 32'd0; e_lo0 = 32'd0; e_lo1 = 32'd0;
      fill_base();

      vecs[0]  = '{1'b1, 1'b0, 32'hFFFF_FF05, 32'h0,         -1, 32'h0040_2000, 2};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_003F, 32'h0,         -1, 32'h0D5F_E033, 2};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,         -1, 32'h0088_8022, 2};
      vecs[3]  = '{1'b0, 1'b1, 32'h0,         32'h0040_2011, -1, 32'h0000_0009, EE ? 11 : 65};
      vecs[4]  = '{1'b0, 1'b1, 32'h0,         32'h0088_8011, -1, 32'h0000_0003, EE ? 5 : 65};
      vecs[5]  = '{1'b0, 1'b1, 32'h0,         32'h0088_8022, -1, 32'h0000_0003, EE ? 5 : 65};
      vecs[6]  = '{1'b0, 1'b1, 32'h0,         32'h1234_5678, -1, 32'h8000_0000, 65};
      vecs[7]  = '{1'b0, 1'b1, 32'h0,         32'h0D58_0033, -1, 32'h0000_0000, EE ? 2 : 65};
      vecs[8]  = '{1'b0, 1'b1, 32'h0,         32'h0D5F_E033, -1, 32'h0000_003F, 65};
      vecs[9]  = '{1'b0, 1'b1, 32'h0,         32'h0040_2000, -1, 32'h0000_0005, EE ? 7 : 65};
      vecs[10] = '{1'b1, 1'b1, 32'h0000_0005, 32'h0040_2011, 10, 32'h0000_0009, EE ? 11 : 65};

      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk);
      res = 1'b1;

      for (int v = 0; v < 11; v++)
         run_op(vecs[v].rd, vecs[v].pr, vecs[v].index, vecs[v].ehi,
                vecs[v].inject, 1'b1, vecs[v].key, vecs[v].lat);

      abort_test();

      fill_random();
      for (int n = 0; n < 30; n++) begin
         int r;
         r = int'($urandom_range(0, 3));
         run_op((r == 0) || (r == 1), (r != 0), $urandom,
                {19'($urandom_range(0, 47)), 5'($urandom), 8'($urandom_range(0, 3))},
                -1, 1'b0, 32'd0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
